weight_reg_pingpong: RTL

//  Double-buffered (ping-pong) convolution weight register matrix with valid/ready load handshake and

---
 rtl/weight_reg_pingpong.sv | 78 +++++++
 1 files changed

// File: rtl/weight_reg_pingpong.sv
// weight_reg_pingpong: double-buffered weight matrix; loads shift into the free bank while
// the consumer reads the other, with bank swapping handled by full flags and a release pulse.
module weight_reg_pingpong #(
    parameter int FW = 16,
    parameter int DW = 512,
    parameter int MS = 32,
    parameter int KS = 3,
    localparam int PL = (DW / FW > 0) ? DW / FW : 1,
    localparam int ML = MS * KS * KS,
    localparam int PN = (ML / PL > 0) ? ML / PL : 1,
    localparam int CW = (PN > 1) ? $clog2(PN) : 1,
    localparam int BW = ML * FW
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          flush_i,
    input  logic          data_valid_i,
    input  logic [DW-1:0] data_i,
    output logic          data_ready_o,
    input  logic          rd_release_i,
    output logic          weight_valid_o,
    output logic [BW-1:0] weight_o,
    output logic          wr_bank_o,
    output logic          rd_bank_o,
    output logic [CW-1:0] load_cnt_o
);
    if (DW % FW != 0 || ML % PL != 0) begin : g_cfg_err
        $error("weight_reg_pingpong: DW must be a multiple of FW and MATRIX_LEN a multiple of PACKAGE_LEN");
    end

    logic [BW-1:0] bank_q [2];
    logic [BW-1:0] shift_d;
    logic [1:0]    full_q, full_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept, last, release_rd;

    assign data_ready_o   = ~full_q[wr_bank_q] & ~flush_i;
    assign accept         = data_valid_i & data_ready_o;
    assign last           = accept & (cnt_q == CW'(PN - 1));
    assign release_rd     = rd_release_i & full_q[rd_bank_q] & ~flush_i;
    assign weight_valid_o = full_q[rd_bank_q];
    assign weight_o       = bank_q[rd_bank_q];
    assign wr_bank_o      = wr_bank_q;
    assign rd_bank_o      = rd_bank_q;
    assign load_cnt_o     = cnt_q;

    // Newest beat lands in the low words; older beats move up by one package.
    assign shift_d = BW'({bank_q[wr_bank_q], data_i});

    // Completion and release always hit different banks, so set/clear never collide.
    always_comb begin
        full_d    = flush_i ? 2'b00
                  : (full_q | (last ? {wr_bank_q, ~wr_bank_q} : 2'b00))
                    & ~(release_rd ? {rd_bank_q, ~rd_bank_q} : 2'b00);
        cnt_d     = flush_i ? '0 : last ? '0 : accept ? cnt_q + CW'(1) : cnt_q;
        wr_bank_d = flush_i ? 1'b0 : last ? ~wr_bank_q : wr_bank_q;
        rd_bank_d = flush_i ? 1'b0 : release_rd ? ~rd_bank_q : rd_bank_q;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            bank_q[0] <= '0;
            bank_q[1] <= '0;
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (accept) bank_q[wr_bank_q] <= shift_d;
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule
